// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Purpose  : FSM state encoding, bus widths and parameter defaults for sram_ctrl
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

  localparam int c_addr_w = 20;
  localparam int c_data_w = 32;
  localparam int c_be_w   = 4;

  localparam int c_rd_wait_def  = 2;
  localparam int c_wr_setup_def = 1;
  localparam int c_wr_pulse_def = 2;
  localparam int c_wr_hold_def  = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WS   = 3'd2,
    ST_WP   = 3'd3,
    ST_WH   = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  // Phase counter counts down to zero, so a phase of N cycles starts at N-1.
  function automatic logic [3:0] phase_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_if
// Purpose  : request/response handshake bundle between a client and sram_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface sram_ctrl_if;
  import sram_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [c_addr_w-1:0]   req_addr;
  logic [c_be_w-1:0]     req_wstrb;
  logic [c_data_w-1:0]   req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [c_data_w-1:0]   resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wstrb, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wstrb, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : single-outstanding controller for an asynchronous SRAM with
//            programmable read wait and write setup/pulse/hold phases
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int RD_WAIT  = c_rd_wait_def,
  parameter int WR_SETUP = c_wr_setup_def,
  parameter int WR_PULSE = c_wr_pulse_def,
  parameter int WR_HOLD  = c_wr_hold_def
) (
  input  wire logic                clk,
  input  wire logic                resetn,
  sram_ctrl_if.slave               bus,
  inout  wire [c_data_w-1:0]       ram_data,
  output logic [c_addr_w-1:0]      ram_addr,
  output logic [c_be_w-1:0]        ram_be_n,
  output logic                     ram_ce_n,
  output logic                     ram_oe_n,
  output logic                     ram_we_n
);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [c_data_w-1:0]   r_rdata;
  logic [c_data_w-1:0]   r_wdata;
  logic                  r_drive_en;
  logic [c_addr_w-1:0]   r_addr;
  logic [c_be_w-1:0]     r_be_n;
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;

  wire w_accept     = bus.req_valid && r_req_ready;
  wire w_phase_done = (r_cnt == 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_wdata      <= '0;
      r_drive_en   <= 1'b0;
      r_addr       <= '0;
      r_be_n       <= '1;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_addr      <= bus.req_addr;
            r_ce_n      <= 1'b0;
            if (bus.req_we) begin
              r_state    <= ST_WS;
              r_cnt      <= phase_load(WR_SETUP);
              r_be_n     <= ~bus.req_wstrb;
              r_wdata    <= bus.req_wdata;
              r_drive_en <= 1'b1;
              r_rdata    <= '0;
            end else begin
              r_state <= ST_RD;
              r_cnt   <= phase_load(RD_WAIT);
              r_be_n  <= '0;
              r_oe_n  <= 1'b0;
            end
          end
        end

        ST_RD: begin
          if (w_phase_done) begin
            r_rdata      <= ram_data;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_be_n       <= '1;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_WS: begin
          if (w_phase_done) begin
            r_we_n  <= 1'b0;
            r_cnt   <= phase_load(WR_PULSE);
            r_state <= ST_WP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_WP: begin
          if (w_phase_done) begin
            r_we_n  <= 1'b1;
            r_cnt   <= phase_load(WR_HOLD);
            r_state <= ST_WH;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        // Address, data and byte enables stay put until the hold phase ends.
        ST_WH: begin
          if (w_phase_done) begin
            r_ce_n       <= 1'b1;
            r_be_n       <= '1;
            r_drive_en   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Data bus is only driven during write phases, never while oe_n is low.
  assign ram_data = r_drive_en ? r_wdata : {c_data_w{1'bz}};

  assign ram_addr       = r_addr;
  assign ram_be_n       = r_be_n;
  assign ram_ce_n       = r_ce_n;
  assign ram_oe_n       = r_oe_n;
  assign ram_we_n       = r_we_n;
  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl
// Purpose  : randomized self-checking bench for sram_ctrl with an async SRAM model
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;
  import sram_pkg::*;

  localparam int RD_WAIT  = 2;
  localparam int WR_SETUP = 1;
  localparam int WR_PULSE = 2;
  localparam int WR_HOLD  = 1;
  localparam int c_rd_lat = RD_WAIT + 1;
  localparam int c_wr_lat = WR_SETUP + WR_PULSE + WR_HOLD + 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if bus ();
  wire  [31:0] ram_data;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n;

  sram_ctrl #(
    .RD_WAIT (RD_WAIT),
    .WR_SETUP(WR_SETUP),
    .WR_PULSE(WR_PULSE),
    .WR_HOLD (WR_HOLD)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .ram_data(ram_data),
    .ram_addr(ram_addr),
    .ram_be_n(ram_be_n),
    .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n)
  );

  // Asynchronous SRAM pin model: combinational read, write sampled inside the we_n pulse.
  logic [31:0] sram_mem [bit [19:0]];
  logic [31:0] sram_q;
  int          sram_wr_cnt = 0;

  function automatic logic [31:0] sram_rd(input logic [19:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : 32'h0;
  endfunction

  always @(ram_addr, sram_wr_cnt) sram_q = sram_rd(ram_addr);
  assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? sram_q : 32'hzzzzzzzz;

  always @(negedge ram_we_n) begin
    #8;
    if (!ram_we_n && !ram_ce_n) begin
      logic [31:0] w;
      w = sram_rd(ram_addr);
      for (int b = 0; b < 4; b++)
        if (!ram_be_n[b]) w[b*8 +: 8] = ram_data[b*8 +: 8];
      sram_mem[ram_addr] = w;
      sram_wr_cnt++;
    end
  end

  int we_falls = 0;
  always @(negedge ram_we_n) we_falls++;

  int overlap_cnt = 0;
  always @(negedge clk)
    if (resetn && !ram_oe_n && (dut.r_drive_en || !ram_we_n)) overlap_cnt++;

  // Reference: word memory updated by byte-strobe merge.
  logic [31:0] ref_mem [bit [19:0]];

  function automatic logic [31:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_d;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
    return r;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [19:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output int lat);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wstrb = wstrb;
    bus.req_wdata = wdata;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_val("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check_val("resp_timeout", 32'(lat), 32'd0);
    rdata = bus.resp_rdata;
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [19:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input int hold);
    logic [31:0] rd;
    int          lat;
    run_txn(1'b1, addr, wstrb, wdata, hold, rd, lat);
    check_val({tag, "_wr_lat"}, 32'(lat), 32'(c_wr_lat));
    check_val({tag, "_wr_rdata"}, rd, 32'h0);
    ref_mem[addr] = merge(ref_rd(addr), wdata, wstrb);
  endtask

  task automatic do_read(input string tag, input logic [19:0] addr, input logic [31:0] exp,
                         input int hold);
    logic [31:0] rd;
    int          lat;
    run_txn(1'b0, addr, 4'h0, 32'h0, hold, rd, lat);
    check_val({tag, "_rd_lat"}, 32'(lat), 32'(c_rd_lat));
    check_val({tag, "_rd_data"}, rd, exp);
  endtask

  initial begin
    logic [31:0] v0;
    int          g;
    int          falls0;
    int          spurious;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wstrb  = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check_val("rst_addr", 32'(ram_addr), 32'h0);
    check_val("rst_be_n", 32'(ram_be_n), 32'hf);
    check_val("rst_ctl", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
    check_val("rst_drive", 32'(dut.r_drive_en), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Basic write/read and latency
    do_write("basic", 20'h00010, 4'hf, 32'hDEADBEEF, 0);
    do_read ("basic", 20'h00010, 32'hDEADBEEF, 0);

    // Byte-lane merge
    do_write("lane_full", 20'h00020, 4'hf, 32'h11223344, 1);
    do_write("lane_part", 20'h00020, 4'b0101, 32'hAABBCCDD, 0);
    do_read ("lane", 20'h00020, 32'h11BB33DD, 2);

    // Zero-strobe write still pulses we_n but changes nothing
    falls0 = we_falls;
    do_write("zstrb", 20'h00010, 4'h0, 32'hFFFFFFFF, 0);
    check_val("zstrb_we_pulse", 32'(we_falls - falls0), 32'd1);
    do_read ("zstrb", 20'h00010, 32'hDEADBEEF, 0);

    // Address boundaries
    do_write("bnd_lo", 20'h00000, 4'hf, 32'h5A5A5A5A, 0);
    do_write("bnd_hi", 20'hFFFFF, 4'hf, 32'hA5A5A5A5, 0);
    do_read ("bnd_lo", 20'h00000, 32'h5A5A5A5A, 0);
    do_read ("bnd_hi", 20'hFFFFF, 32'hA5A5A5A5, 1);

    // Backpressure: response held, second request must wait
    do_write("bp", 20'h00200, 4'hf, 32'hC0FFEE01, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 20'h00200;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    g = 0;
    while (!bus.resp_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check_val("bp_resp_timeout", 32'(g), 32'd0);
    v0 = bus.resp_rdata;
    check_val("bp_first_data", v0, 32'hC0FFEE01);
    bus.req_valid = 1'b1;
    bus.req_addr  = 20'h00010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_valid_hold", 32'(bus.resp_valid), 32'd1);
      check_val("bp_data_hold", bus.resp_rdata, v0);
      check_val("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    check_val("bp_ready_after", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    g = 1;
    while (!bus.resp_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_val("bp_second_lat", 32'(g), 32'(c_rd_lat));
    check_val("bp_second_data", bus.resp_rdata, 32'hDEADBEEF);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;

    // Randomized traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      logic [19:0] a;
      a = 20'h00100 + 20'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        do_write("rnd", a, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
      else
        do_read("rnd", a, ref_rd(a), $urandom_range(0, 3));
    end

    // Reset during the write pulse abandons the transaction
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 20'h55555;
    bus.req_wstrb = 4'hf;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    g = 0;
    while (ram_we_n && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check_val("rstwp_no_pulse", 32'(g), 32'd0);
    resetn = 1'b0;
    #1;
    check_val("rstwp_we_n", 32'(ram_we_n), 32'd1);
    check_val("rstwp_ce_n", 32'(ram_ce_n), 32'd1);
    check_val("rstwp_drive", 32'(dut.r_drive_en), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) spurious++;
    end
    check_val("rstwp_no_resp", 32'(spurious), 32'd0);
    check_val("rstwp_req_ready", 32'(bus.req_ready), 32'd1);
    check_val("rstwp_addr", 32'(ram_addr), 32'h0);
    check_val("rstwp_be_n", 32'(ram_be_n), 32'hf);

    // Controller still works after the abandoned write
    do_read("post_rst", 20'h00020, 32'h11BB33DD, 0);

    check_val("oe_drive_overlap", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter RD_WAIT, default 2, meaning read access cycles with ce_n/oe_n low before data capture (legal 1..15).
REQ-002 SHALL have parameter WR_SETUP, default 1, meaning cycles with address, data and ce_n driven before we_n falls (legal 1..15).
REQ-003 SHALL have parameter WR_PULSE, default 2, meaning cycles we_n is held low (legal 2..15; at 100 MHz this covers the model's 10 ns write sampling delay).
REQ-004 SHALL have parameter WR_HOLD, default 1, meaning cycles address, data and be_n stay driven after we_n rises (legal 1..15).
REQ-005 SHALL have ports, clock and reset first:
clk  in  1  single clock; all state updates on rising edge
resetn  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  20  SRAM word address
req_wstrb  in  4  byte enables for writes, active-high
req_wdata  in  32  write data
resp_valid  out  1  response present
resp_ready  in  1  response consumed this cycle
resp_rdata  out  32  read data (0 for writes)
ram_data  inout  32  SRAM data bus
ram_addr  out  20  SRAM address
ram_be_n  out  4  byte enables, active-low
ram_ce_n  out  1  chip enable, active-low
ram_oe_n  out  1  output enable, active-low
ram_we_n  out  1  write enable, active-low

Function
REQ-006 SHALL implement FSM states IDLE, RD, WS (write setup), WP (write pulse), WH (write hold), RESP.
REQ-007 SHALL assert req_ready only in IDLE; a transfer is accepted when req_valid and req_ready are both high on a rising edge, and request fields are registered at acceptance.
REQ-008 SHALL allow at most one outstanding transaction; no new request is accepted until the response handshake completes.
REQ-009 SHALL transition IDLE->RD on an accepted read; in RD drive ce_n=0, oe_n=0, we_n=1, be_n=0000 and the registered address for exactly RD_WAIT cycles.
REQ-010 SHALL capture ram_data into resp_rdata on the last RD cycle, then go to RESP with ce_n=oe_n=1.
REQ-011 SHALL transition IDLE->WS on an accepted write; WS drives ce_n=0, oe_n=1, we_n=1, be_n=~wstrb, address and data for WR_SETUP cycles; WP additionally drives we_n=0 for WR_PULSE cycles; WH restores we_n=1 with ce_n, address, data and be_n unchanged for WR_HOLD cycles; then RESP.
REQ-012 SHALL drive ram_data only in WS, WP and WH; in all other states ram_data SHALL be high-impedance (32'hzzzzzzzz).
REQ-013 SHALL never have oe_n=0 and the data driver enabled in the same cycle; oe_n and we_n SHALL never both be low.
REQ-014 SHALL hold resp_valid=1 in RESP with stable resp_rdata until resp_ready=1, then return to IDLE on the next edge.
REQ-015 SHALL treat a write with req_wstrb=0000 as a normal write cycle (we_n still pulses, be_n=1111, memory unchanged).
REQ-016 SHALL give read latency of acceptance edge + RD_WAIT + 1 cycles to resp_valid; write latency is acceptance edge + WR_SETUP + WR_PULSE + WR_HOLD + 1.
REQ-017 SHALL implement the phase counter as 4 bits, loaded with (parameter - 1) on phase entry, decrementing to 0, with no wrap-around.

Reset
REQ-018 SHALL, while resetn=0 (asynchronously), force state IDLE, req_ready=1 once resetn deasserts, resp_valid=0, resp_rdata=0, ram_addr=0, ram_be_n=1111, ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_data high-impedance.
REQ-019 SHALL, when reset is asserted during a write pulse, raise we_n immediately and abandon the transaction without generating a response.

Structure
REQ-020 SHALL place the FSM state encoding and the parameter default values in a shared package sram_pkg.
REQ-021 SHALL have no sub-modules; the tristate driver is inline logic with a registered output-enable.

Verification
REQ-022 SHALL, using the team's single-port async SRAM simulation model on the pins with Init_File="none": write 0xDEADBEEF with wstrb=1111 to addr 0x00010, then read addr 0x00010 -> resp_rdata=0xDEADBEEF; read resp_valid 3 cycles after acceptance, write resp_valid 5 cycles after acceptance (defaults).
REQ-023 SHALL verify a byte-lane write: write 0x11223344 full, then write 0xAABBCCDD with wstrb=0101 to the same addr -> read returns 0x11BB33DD.
REQ-024 SHALL verify backpressure: hold resp_ready=0 for 5 cycles after a read -> resp_valid and resp_rdata stay stable, req_ready=0, and a second req_valid is not accepted until resp_ready=1.
REQ-025 SHALL verify reset mid-write: assert resetn=0 in WP -> we_n=1 and ce_n=1 within the same timestep, ram_data=Z, no resp_valid after reset release.
REQ-026 SHALL verify boundary addresses 0x00000 and 0xFFFFF with the model at AW=20 -> write/read back 0x5A5A5A5A and 0xA5A5A5A5 correctly; an assertion checks that oe_n=0 never coincides with the driven ram_data.
